branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Fetch-stage direction + target predictor; produces PCSrcPredF / PredPCTargetF consumed by branch_control_unit.
//  Bimodal table of 2-bit saturating counters plus tagged branch target buffer (BTB), both indexed by PC.
//  Lookup is combinational in F; training is synchronous from Execute-stage resolution (PCSrcResE, PCTargetE).
// PARAMETERS
//  WIDTH     32  PC / target width
//  IDX_BITS  6   log2 entries of counter table and BTB (64 entries)
//  TAG_BITS  8   BTB tag width, tag = PC[IDX_BITS+TAG_BITS+1 : IDX_BITS+2]
// PORTS
//  clk            in   1         clock, all state updates on rising edge
//  reset          in   1         synchronous, active-high
//  PCF            in   WIDTH     fetch PC (lookup address)
//  PCE            in   WIDTH     PC of instruction in Execute
//  BranchOpEb0    in   1         Execute instruction is branch/jump (training valid)
//  StallE         in   1         Execute stalled; suppresses training this cycle
//  PCSrcResE      in   1         resolved direction: 1 = taken
//  PCTargetE      in   WIDTH     resolved target
//  PCSrcPredF     out  1         predict taken this fetch
//  PredPCTargetF  out  WIDTH     predicted target; 0 when PCSrcPredF = 0
// BEHAVIOUR
//  Indexing: idx = PC[IDX_BITS+1:2]; PC[1:0] ignored. idxF from PCF, idxE from PCE.
//  Lookup (comb): hitF = btb_valid[idxF] && btb_tag[idxF] == tagF.
//   PCSrcPredF = hitF && ctr[idxF][1]; PredPCTargetF = PCSrcPredF ? btb_tgt[idxF] : 0.
//  Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  Training enable: trainE = BranchOpEb0 && !StallE && !reset.
//  On trainE, next edge:
//   - ctr[idxE] += 1 if PCSrcResE, -= 1 otherwise; saturate at 11 and 00 (no wrap).
//   - if PCSrcResE: btb_valid[idxE]<=1, btb_tag[idxE]<=tagE, btb_tgt[idxE]<=PCTargetE
//     (allocate or overwrite; aliased entry replaced).
//   - if !PCSrcResE: BTB untouched (entry kept for later re-taken).
//  Read/write same index same cycle: F lookup sees pre-update value; new value visible next cycle.
//  No F-side state: lookup has zero-cycle latency, training one-cycle latency.
//  Reset (sync, one cycle): all ctr <= 01, all btb_valid <= 0; tags/targets don't-care.
//   Outputs during/after reset: PCSrcPredF = 0, PredPCTargetF = 0 until first taken training.
//  Reset asserted with trainE inputs high: reset wins, no training.
//  StallE high: state held; a stalled branch trains exactly once, on its unstalled cycle.
//  Misprediction recovery/flush is branch_control_unit's job; this block only trains.
// STRUCTURE
//  branch_pkg: typedef enum logic [1:0] {STRONG_UNTAKEN, WEAK_UNTAKEN, WEAK_TAKEN, STRONG_TAKEN} bp_ctr_t;
//   constant BP_CTR_RESET = WEAK_UNTAKEN.
//  Sub-module branch_target_buffer: valid/tag/target arrays, comb lookup, sync write port;
//   counter table + saturation logic stay in branch_predictor.
// TESTING
//  1 reset, PCF=0x100 -> PCSrcPredF=0, PredPCTargetF=0; all ctr read 01.
//  2 PCE=0x100, PCTargetE=0x80, PCSrcResE=1, BranchOpEb0=1, 1 cycle -> PCF=0x100 gives
//    PCSrcPredF=1, PredPCTargetF=0x80 (ctr 01->10, BTB allocated).
//  3 same branch taken 3 more times -> ctr saturates 11; then 1x untaken -> ctr 10, still
//    predicts taken 0x80; 2nd untaken -> 01, PCSrcPredF=0, target 0.
//  4 alias: PCE=0x100+(1<<(IDX_BITS+2)) taken to 0x200 -> PCF=0x100 misses tag, PCSrcPredF=0;
//    aliased PC predicts 0x200.
//  5 StallE=1 for 3 cycles with BranchOpEb0=1, PCSrcResE=1 -> no state change; then StallE=0
//    -> exactly one increment.
//  6 train to strong-T, assert reset with trainE inputs active -> next cycle PCSrcPredF=0,
//    ctr=01, BTB invalid.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit direction counter and
// its saturating update rule.
package branch_pkg;

  typedef enum logic [1:0] {
    STRONG_UNTAKEN,
    WEAK_UNTAKEN,
    WEAK_TAKEN,
    STRONG_TAKEN
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WEAK_UNTAKEN;

  // Saturating step toward the resolved direction; never wraps.
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t cur, input logic taken);
    bp_ctr_t nxt;
    nxt = cur;
    unique case (cur)
      STRONG_UNTAKEN: nxt = taken ? WEAK_UNTAKEN : STRONG_UNTAKEN;
      WEAK_UNTAKEN:   nxt = taken ? WEAK_TAKEN   : STRONG_UNTAKEN;
      WEAK_TAKEN:     nxt = taken ? STRONG_TAKEN : WEAK_UNTAKEN;
      STRONG_TAKEN:   nxt = taken ? STRONG_TAKEN : WEAK_TAKEN;
      default:        nxt = BP_CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged target buffer: combinational lookup, one synchronous write port.
// Only valid bits are reset; tags and targets are qualified by valid.
module branch_target_buffer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  input  logic [TAG_BITS-1:0] rd_tag_i,
  output logic                hit_o,
  output logic [WIDTH-1:0]    tgt_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  logic [WIDTH-1:0]    wr_tgt_i
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic [Entries-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [Entries];
  logic [WIDTH-1:0]    tgt_q [Entries];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i && !reset) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      tgt_q[wr_idx_i] <= wr_tgt_i;
    end
  end

  always_comb begin
    hit_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    tgt_o = tgt_q[rd_idx_i];
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage bimodal direction predictor plus BTB. Lookup is combinational on PCF;
// training happens on the clock edge from the resolved Execute-stage branch.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCF,
  input  logic [WIDTH-1:0] PCE,
  input  logic             BranchOpEb0,
  input  logic             StallE,
  input  logic             PCSrcResE,
  input  logic [WIDTH-1:0] PCTargetE,
  output logic             PCSrcPredF,
  output logic [WIDTH-1:0] PredPCTargetF
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned IdxLo   = 2;
  localparam int unsigned TagLo   = IDX_BITS + 2;
  localparam int unsigned TagHi   = IDX_BITS + TAG_BITS + 1;

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic                train_e;
  logic                hit_f;
  logic [WIDTH-1:0]    btb_tgt_f;
  bp_ctr_t             ctr_q [Entries];
  bp_ctr_t             ctr_d;

  assign idx_f = PCF[TagLo-1:IdxLo];
  assign idx_e = PCE[TagLo-1:IdxLo];
  assign tag_f = PCF[TagHi:TagLo];
  assign tag_e = PCE[TagHi:TagLo];

  // Byte offset and bits above the tag take no part in indexing or matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[WIDTH-1:TagHi+1], PCF[1:0], PCE[WIDTH-1:TagHi+1], PCE[1:0]};

  assign train_e = BranchOpEb0 && !StallE && !reset;
  assign ctr_d   = bp_ctr_next(ctr_q[idx_e], PCSrcResE);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= BP_CTR_RESET;
      end
    end else if (train_e) begin
      ctr_q[idx_e] <= ctr_d;
    end
  end

  // Not-taken resolutions leave the BTB entry in place for a later re-taken branch.
  branch_target_buffer #(
    .WIDTH    (WIDTH),
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx_i (idx_f),
    .rd_tag_i (tag_f),
    .hit_o    (hit_f),
    .tgt_o    (btb_tgt_f),
    .we_i     (train_e && PCSrcResE),
    .wr_idx_i (idx_e),
    .wr_tag_i (tag_e),
    .wr_tgt_i (PCTargetE)
  );

  always_comb begin
    PCSrcPredF    = hit_f && ctr_q[idx_f][1];
    PredPCTargetF = PCSrcPredF ? btb_tgt_f : '0;
  end

endmodule
